// File: rtl/pipereg_pkg.sv
// pipereg_pkg -- shared definitions for the elastic pipeline register.
//   * pipe_state_e : occupancy of the two-entry skid buffer
//   * CTRL_W_DEF / DATA_W_DEF : default widths of the control and data bundles
//   * control / data field bit positions inside the bundles
//   * held_count() : number of entries held in a given state
package pipereg_pkg;

   localparam int CTRL_W_DEF = 11;
   localparam int DATA_W_DEF = 100;

   // Control bundle: {pcload, regw, memw, regmem, branch, ALUope, flag, ALUctrl[3:0]}
   localparam int CTRL_PCLOAD_BIT  = 10;
   localparam int CTRL_REGW_BIT    = 9;
   localparam int CTRL_MEMW_BIT    = 8;
   localparam int CTRL_REGMEM_BIT  = 7;
   localparam int CTRL_BRANCH_BIT  = 6;
   localparam int CTRL_ALUOPE_BIT  = 5;
   localparam int CTRL_FLAG_BIT    = 4;
   localparam int CTRL_ALUCTRL_MSB = 3;
   localparam int CTRL_ALUCTRL_LSB = 0;

   // Data bundle: {regScr[3:0], regA[31:0], regB[31:0], inm[31:0]}
   localparam int DATA_REGSCR_LSB = 96;
   localparam int DATA_REGA_LSB   = 64;
   localparam int DATA_REGB_LSB   = 32;
   localparam int DATA_INM_LSB    = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

   function automatic logic [1:0] held_count(input pipe_state_e st);
      logic [1:0] n;
      case (st)
         ST_EMPTY: n = 2'd0;
         ST_ONE:   n = 2'd1;
         ST_TWO:   n = 2'd2;
         default:  n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pipereg_sat_cnt.sv
// pipereg_sat_cnt -- up-counter that adds a small increment each cycle and
// sticks at all-ones instead of wrapping.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset, clears the count
//   inc : amount added on this edge (0 keeps the count)
//   cnt : current count
module pipereg_sat_cnt #(
   parameter int WIDTH = 16,
   parameter int INC_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [INC_W-1:0] inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH:0]   sum_s;

   // Next count: one extra bit catches the carry that signals saturation.
   always_comb begin
      sum_s = {1'b0, cnt_q} + {{(WIDTH + 1 - INC_W){1'b0}}, inc};
      if (sum_s[WIDTH]) begin
         cnt_d = {WIDTH{1'b1}};
      end else begin
         cnt_d = sum_s[WIDTH-1:0];
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {WIDTH{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipereg_elastic.sv
// pipereg_elastic -- elastic valid/ready pipeline register built as a
// two-entry skid buffer (main + skid). Output always comes from main; the
// skid catches the entry accepted while downstream stalls, which lets
// in_ready be a flop without losing throughput.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : synchronous kill of everything held (wins over transfers)
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_ctrl/in_data     : upstream control / data bundles
//   out_valid/out_ready : downstream handshake
//   out_ctrl/out_data   : presented bundles; out_ctrl is zero on bubbles,
//                         out_data keeps its last value
// Optional feature macro PIPEREG_STATS_EN adds kill_cnt / stall_cnt (16-bit,
// saturating): entries discarded by flush, and cycles stalled downstream.
module pipereg_elastic
   import pipereg_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPEREG_STATS_EN
   ,
   output logic [15:0]       kill_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   pipe_state_e       state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              in_fire_s;
   logic              out_fire_s;

   assign in_fire_s  = in_valid & in_ready_q;
   assign out_fire_s = out_valid_q & out_ready;

   // Next-state and storage update; main's control is cleared whenever the
   // buffer empties so the presented control is a bubble.
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         main_ctrl_d = {CTRL_W{1'b0}};
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (in_fire_s) begin
                  state_d     = ST_TWO;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (out_fire_s) begin
                  state_d     = ST_EMPTY;
                  main_ctrl_d = {CTRL_W{1'b0}};
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only the output side can move.
               if (out_fire_s) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
               end else begin
                  state_d = ST_TWO;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_ctrl_d = {CTRL_W{1'b0}};
            end
         endcase
      end
      // Handshake flops follow the state they will describe next cycle.
      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // State, storage and handshake registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= {CTRL_W{1'b0}};
         main_data_q <= {DATA_W{1'b0}};
         skid_ctrl_q <= {CTRL_W{1'b0}};
         skid_data_q <= {DATA_W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_ctrl  = main_ctrl_q;
   assign out_data  = main_data_q;

`ifdef PIPEREG_STATS_EN
   logic [1:0] kill_inc_s;
   logic [1:0] stall_inc_s;

   // Counter increments: entries discarded by a flush, and stalled cycles.
   always_comb begin
      if (flush) begin
         kill_inc_s = held_count(state_q);
      end else begin
         kill_inc_s = 2'd0;
      end
      if (out_valid_q && !out_ready) begin
         stall_inc_s = 2'd1;
      end else begin
         stall_inc_s = 2'd0;
      end
   end

   pipereg_sat_cnt #(.WIDTH(16), .INC_W(2)) u_kill_cnt (
      .clk (clk),
      .rst (rst),
      .inc (kill_inc_s),
      .cnt (kill_cnt)
   );

   pipereg_sat_cnt #(.WIDTH(16), .INC_W(2)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc_s),
      .cnt (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_pipereg_elastic.sv
// tb_pipereg_elastic -- scoreboard bench for pipereg_elastic. The stimulus
// thread drives directed vectors; a monitor keeps a queue of entries that
// should be held (pushed on an accepted input, popped on a consumed output,
// emptied by flush/reset) and compares the DUT outputs against it on every
// falling edge. Stats checks run when PIPEREG_STATS_EN is defined.
module tb_pipereg_elastic;

   localparam int CW = 11;
   localparam int DW = 100;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
`ifdef PIPEREG_STATS_EN
   logic [15:0]   kill_cnt;
   logic [15:0]   stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   entry_t exp_q[$];
   entry_t vec[3];

   always #5 clk = ~clk;

   pipereg_elastic dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data)
`ifdef PIPEREG_STATS_EN
      ,
      .kill_cnt  (kill_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] mk_data(input logic [3:0] scr, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] inm);
      return {scr, a, b, inm};
   endfunction

   task automatic drive(input entry_t e);
      in_valid = 1'b1;
      in_ctrl  = e.ctrl;
      in_data  = e.data;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_ctrl  = 11'h000;
      in_data  = {DW{1'b0}};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: compare on falling edges, update the model on rising edges.
   initial begin : monitor
      logic   do_push, do_pop, do_flush;
      entry_t cap;
      forever begin
         @(negedge clk);
         do_push  = 1'b0;
         do_pop   = 1'b0;
         do_flush = 1'b0;
         if (rst) begin
            exp_q.delete();
         end else begin
            chk("mon_out_valid", out_valid, (exp_q.size() != 0));
            chk("mon_in_ready", in_ready, (exp_q.size() < 2));
            if (exp_q.size() == 0) begin
               chk("mon_bubble_ctrl", out_ctrl, 11'h000);
            end else begin
               chk("mon_out_ctrl", out_ctrl, exp_q[0].ctrl);
               chk("mon_out_data", out_data, exp_q[0].data);
            end
            do_flush = flush;
            do_pop   = !flush && out_ready && (exp_q.size() != 0);
            do_push  = !flush && in_valid && (exp_q.size() < 2);
            cap.ctrl = in_ctrl;
            cap.data = in_data;
         end
         @(posedge clk);
         if (rst || do_flush) begin
            exp_q.delete();
         end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(cap);
         end
      end
   end

   initial begin : stim
      int  idx;
      int  cyc;
      logic acc;

      vec[0].ctrl = 11'h5A3; vec[0].data = mk_data(4'h3, 32'h0000FFFF, 32'hDEADBEEF, 32'h00000010);
      vec[1].ctrl = 11'h112; vec[1].data = mk_data(4'hA, 32'h00000001, 32'h12345678, 32'hFFFFFFF0);
      vec[2].ctrl = 11'h7FF; vec[2].data = mk_data(4'hF, 32'h00000002, 32'h00000000, 32'h80000001);

      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      idle_in();

      // Reset values while rst is held.
      #2;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_ctrl", out_ctrl, 11'h000);
      chk("rst_out_data", out_data, {DW{1'b0}});
      chk("rst_in_ready", in_ready, 1'b1);
`ifdef PIPEREG_STATS_EN
      chk("rst_kill_cnt", kill_cnt, 16'h0000);
      chk("rst_stall_cnt", stall_cnt, 16'h0000);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_in_ready", in_ready, 1'b1);

      // Stream of three entries at full rate; out_ready high in EMPTY too.
      out_ready = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         drive(vec[i]);
         step();
         chk("stream_lat_valid", out_valid, 1'b1);
         chk("stream_lat_ctrl", out_ctrl, vec[i].ctrl);
         chk("stream_lat_regA", out_data[95:64], vec[i].data[95:64]);
      end
      idle_in();
      repeat (2) step();
      chk("stream_drained", out_valid, 1'b0);

      // Backpressure: two accepted, third held upstream, then release.
      out_ready = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < 3 && cyc < 20) begin
         drive(vec[idx]);
         out_ready = (cyc >= 5);
         if (cyc == 3) begin
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_head_ctrl", out_ctrl, vec[0].ctrl);
         end
         @(negedge clk);
         acc = in_ready;
         step();
         if (acc) idx++;
         cyc++;
      end
      chk("bp_all_accepted", idx, 3);
      idle_in();
      out_ready = 1'b1;
      repeat (4) step();
      chk("bp_drained", out_valid, 1'b0);

      // Flush in TWO with a valid input offered.
      out_ready = 1'b0;
      drive(vec[0]);
      step();
      drive(vec[1]);
      step();
      chk("fl_pre_in_ready", in_ready, 1'b0);
      drive(vec[2]);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle_in();
      chk("fl_out_valid", out_valid, 1'b0);
      chk("fl_out_ctrl", out_ctrl, 11'h000);
      chk("fl_in_ready", in_ready, 1'b1);
`ifdef PIPEREG_STATS_EN
      chk("fl_kill_cnt", kill_cnt, 16'd2);
`endif
      // Flush held over several cycles while inputs keep arriving.
      flush = 1'b1;
      drive(vec[1]);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flh_in_ready", in_ready, 1'b1);
         chk("flh_out_valid", out_valid, 1'b0);
      end
      flush = 1'b0;
      idle_in();
      step();
`ifdef PIPEREG_STATS_EN
      chk("flh_kill_cnt", kill_cnt, 16'd2);
`endif

      // Asynchronous reset between edges while in ONE.
      out_ready = 1'b0;
      drive(vec[2]);
      step();
      idle_in();
      chk("ar_pre_valid", out_valid, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", out_valid, 1'b0);
      chk("ar_out_ctrl", out_ctrl, 11'h000);
      chk("ar_out_data", out_data, {DW{1'b0}});
      chk("ar_in_ready", in_ready, 1'b1);
`ifdef PIPEREG_STATS_EN
      chk("ar_kill_cnt", kill_cnt, 16'h0000);
      chk("ar_stall_cnt", stall_cnt, 16'h0000);
`endif
      @(negedge clk);
      #1;
      rst = 1'b0;
      step();

`ifdef PIPEREG_STATS_EN
      // Long stall: the counter must stop at all-ones.
      out_ready = 1'b0;
      drive(vec[0]);
      step();
      idle_in();
      chk("st_first", stall_cnt, 16'd0);
      step();
      chk("st_one", stall_cnt, 16'd1);
      repeat (70000) @(posedge clk);
      #1;
      chk("st_saturated", stall_cnt, 16'hFFFF);
`endif

      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
